// File: rtl/zero_detect_arbiter.sv
// zero_detect_arbiter: round-robin arbiter sharing one external all-zeros detector among N requesters
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   req, data         : per-requester request and W-bit operand (requester i owns data[i*W +: W])
//   gnt               : one-hot grant of the requester being served, zero when idle
//   det_in, det_s     : registered operand to the shared detector, detector result back
//   resp_valid/zero/id: result handshake, accepted by resp_ack
//   busy, zero_cnt    : transaction in flight, saturating count of zero results
module zero_detect_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   det_in,
    input  logic           det_s,
    output logic           resp_valid,
    output logic           resp_zero,
    output logic [IDW-1:0] resp_id,
    input  logic           resp_ack,
    output logic           busy,
    output logic [7:0]     zero_cnt
);
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] sel;
    logic [W-1:0]   sel_data;
    // scan from the farthest offset down so the requester nearest ptr wins
    always_comb begin
        sel      = '0;
        sel_data = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                sel      = IDW'((int'(ptr) + k) % N);
                sel_data = data[((int'(ptr) + k) % N) * W +: W];
            end
        end
    end
    assign busy = (state != IDLE);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            det_in     <= '0;
            resp_valid <= 1'b0;
            resp_zero  <= 1'b0;
            resp_id    <= '0;
            ptr        <= '0;
            zero_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    gnt     <= N'(1) << sel;
                    det_in  <= sel_data;
                    resp_id <= sel;
                    state   <= EVAL;
                end
                EVAL: begin
                    resp_zero  <= det_s;
                    resp_valid <= 1'b1;
                    if (det_s && zero_cnt != 8'hFF) zero_cnt <= zero_cnt + 1'b1;
                    state      <= RESP;
                end
                RESP: if (resp_ack) begin
                    resp_valid <= 1'b0;
                    gnt        <= '0;
                    ptr        <= (resp_id == IDW'(N - 1)) ? '0 : resp_id + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
